// File: rtl/hms_alarm_pkg.sv
// hms_alarm_pkg
// Shared definitions for the alarm controller and its helpers:
//   - al_state_t : alarm FSM state encoding (IDLE/ARMED/RING/SNOOZE)
//   - ADDR_MIN / ADDR_HRS : programming bus addresses of the alarm registers
//   - HRS_MAX / MIN_MAX : largest legal alarm hour / minute values
//   - CNT_W : width of the ring and snooze second counters
//   - in_range() : range check applied to programming writes
package hms_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } al_state_t;

  localparam logic [1:0] ADDR_MIN = 2'd2;
  localparam logic [1:0] ADDR_HRS = 2'd3;

  localparam logic [5:0] HRS_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  // Covers the full 1..511 parameter range of ring and snooze durations.
  localparam int CNT_W = 9;

  // True when a programming value may be written to a register whose
  // largest legal value is lim.
  function automatic logic in_range(input logic [5:0] val, input logic [5:0] lim);
    return (val <= lim);
  endfunction

endpackage

// File: rtl/hms_alarm_ctrl_sec_tick.sv
// hms_sec_tick
// Turns the live seconds count of the time-of-day counter into a one-cycle
// "second elapsed" pulse. Any change of seconds counts, including a change
// caused by loading the clock, so any consumer of the counter can reuse it.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   i_sec  in   live seconds (0..59)
//   o_tick out  1 in every cycle where i_sec differs from last cycle's value
module hms_sec_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] i_sec,
  output logic       o_tick
);
  import hms_alarm_pkg::*;

  logic [5:0] r_sec_q;

  // Remember last cycle's seconds value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sec_q <= 6'd0;
    end else begin
      r_sec_q <= i_sec;
    end
  end

  assign o_tick = (i_sec != r_sec_q);

endmodule

// File: rtl/hms_alarm_ctrl.sv
// hms_alarm_ctrl
// Alarm controller sitting downstream of the hrs/min/sec time-of-day counter.
// Holds a programmable alarm time (seconds fixed at 0), rings the buzzer when
// live time reaches it, stops ringing after RING_SEC seconds, and allows up to
// MAX_SNOOZE snoozes of SNOOZE_SEC seconds each per alarm event.
// Build option: define HMS_ALARM_BEEP_EN to make the buzzer toggle once per
// second while ringing (1 s on / 1 s off); otherwise it is steady while ringing.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   hrs, min, sec     live time of day
//   din, addr, load   programming bus (addr 2 = alarm minutes, 3 = alarm hours)
//   arm               level enable for the alarm
//   snooze, stop      single-cycle user requests
//   buzzer            registered buzzer drive
//   al_state          current FSM state (0 IDLE, 1 ARMED, 2 RING, 3 SNOOZE)
//   al_hrs, al_min    programmed alarm time
//   snz_left          snoozes still available for the current alarm event
module hms_alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic [5:0] din,
  input  logic [1:0] addr,
  input  logic       load,
  input  logic       arm,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzzer,
  output logic [1:0] al_state,
  output logic [4:0] al_hrs,
  output logic [5:0] al_min,
  output logic [2:0] snz_left
);
  import hms_alarm_pkg::*;

  localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNZ_LOAD = CNT_W'(SNOOZE_SEC);
  localparam logic [2:0]       SNZ_MAX  = 3'(MAX_SNOOZE);

  al_state_t        r_state;
  al_state_t        w_state_nxt;
  logic [CNT_W-1:0] r_ring_cnt;
  logic [CNT_W-1:0] w_ring_nxt;
  logic [CNT_W-1:0] r_snz_cnt;
  logic [CNT_W-1:0] w_snz_cnt_nxt;
  logic [2:0]       r_snz_left;
  logic [2:0]       w_snz_left_nxt;
  logic             r_buzzer;
  logic             w_buzzer_nxt;
  logic [4:0]       r_al_hrs;
  logic [5:0]       r_al_min;
  logic             w_tick;
  logic             w_match;
  logic [CNT_W-1:0] w_ring_inc;
  logic [CNT_W-1:0] w_snz_dec;

  hms_sec_tick u_sec_tick (
    .clk    (clk),
    .rst    (rst),
    .i_sec  (sec),
    .o_tick (w_tick)
  );

  // Requiring a fresh tick means a match fires once per alarm minute: leaving
  // RING/SNOOZE or re-arming during second 0 sees no new tick.
  assign w_match    = w_tick && (sec == 6'd0) && (hrs == r_al_hrs) && (min == r_al_min);
  assign w_ring_inc = r_ring_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_snz_dec  = r_snz_cnt - {{(CNT_W-1){1'b0}}, 1'b1};

  // Alarm time registers: range-checked writes, accepted in every state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_al_hrs <= 5'd0;
      r_al_min <= 6'd0;
    end else if (load) begin
      if ((addr == ADDR_HRS) && in_range(din, HRS_MAX)) begin
        r_al_hrs <= din[4:0];
      end else if ((addr == ADDR_MIN) && in_range(din, MIN_MAX)) begin
        r_al_min <= din;
      end
    end
  end

  // FSM state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ring_cnt <= {CNT_W{1'b0}};
      r_snz_cnt  <= {CNT_W{1'b0}};
      r_snz_left <= 3'd0;
      r_buzzer   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ring_cnt <= w_ring_nxt;
      r_snz_cnt  <= w_snz_cnt_nxt;
      r_snz_left <= w_snz_left_nxt;
      r_buzzer   <= w_buzzer_nxt;
    end
  end

  // Next-state and counter logic; priority is arm, stop, snooze, timers.
  always_comb begin
    w_state_nxt    = r_state;
    w_ring_nxt     = r_ring_cnt;
    w_snz_cnt_nxt  = r_snz_cnt;
    w_snz_left_nxt = r_snz_left;
    case (r_state)
      ST_IDLE: begin
        if (arm) begin
          w_state_nxt = ST_ARMED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (!arm) begin
          w_state_nxt = ST_IDLE;
        end else if (w_match) begin
          w_state_nxt    = ST_RING;
          w_ring_nxt     = {CNT_W{1'b0}};
          w_snz_left_nxt = SNZ_MAX;
        end else begin
          w_state_nxt = ST_ARMED;
        end
      end
      ST_RING: begin
        if (!arm) begin
          w_state_nxt    = ST_IDLE;
          w_snz_left_nxt = 3'd0;
        end else if (stop) begin
          w_state_nxt    = ST_ARMED;
          w_snz_left_nxt = 3'd0;
        end else if (snooze && (r_snz_left != 3'd0)) begin
          w_state_nxt    = ST_SNOOZE;
          w_snz_cnt_nxt  = SNZ_LOAD;
          w_snz_left_nxt = r_snz_left - 3'd1;
        end else if (w_tick) begin
          // An exhausted snooze request falls through to the ring timer.
          if (w_ring_inc == RING_LIM) begin
            w_state_nxt    = ST_ARMED;
            w_ring_nxt     = {CNT_W{1'b0}};
            w_snz_left_nxt = 3'd0;
          end else begin
            w_ring_nxt = w_ring_inc;
          end
        end else begin
          w_state_nxt = ST_RING;
        end
      end
      ST_SNOOZE: begin
        if (!arm) begin
          w_state_nxt    = ST_IDLE;
          w_snz_left_nxt = 3'd0;
        end else if (stop) begin
          w_state_nxt    = ST_ARMED;
          w_snz_left_nxt = 3'd0;
        end else if (w_tick) begin
          if (w_snz_dec == {CNT_W{1'b0}}) begin
            // Snooze over: ring again with a fresh timeout, snoozes not reloaded.
            w_state_nxt   = ST_RING;
            w_ring_nxt    = {CNT_W{1'b0}};
            w_snz_cnt_nxt = {CNT_W{1'b0}};
          end else begin
            w_snz_cnt_nxt = w_snz_dec;
          end
        end else begin
          w_state_nxt = ST_SNOOZE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_snz_left_nxt = 3'd0;
      end
    endcase
  end

  // Buzzer follows the next state so it lines up with al_state.
  always_comb begin
    w_buzzer_nxt = 1'b0;
`ifdef HMS_ALARM_BEEP_EN
    // Staying in RING: toggle once per second; entering RING starts at 1.
    if ((r_state == ST_RING) && (w_state_nxt == ST_RING)) begin
      w_buzzer_nxt = w_tick ? ~r_buzzer : r_buzzer;
    end else begin
      w_buzzer_nxt = (w_state_nxt == ST_RING);
    end
`else
    w_buzzer_nxt = (w_state_nxt == ST_RING);
`endif
  end

  assign buzzer   = r_buzzer;
  assign al_state = r_state;
  assign al_hrs   = r_al_hrs;
  assign al_min   = r_al_min;
  assign snz_left = r_snz_left;

endmodule

// File: doc/hms_alarm_ctrl.md
Name: hms_alarm_ctrl

Overview:
- Downstream consumer of the hrs/min/sec time-of-day counter.
- Holds a programmable alarm time (hours, minutes; seconds fixed at 0) and compares it against live time.
- Drives a buzzer, with auto-timeout and a bounded snooze count.
- Programmed through the same din/addr/load bus as the clock.

Parameters:
- RING_SEC, 60: seconds the buzzer sounds before auto-stop (1..511).
- SNOOZE_SEC, 300: snooze interval in seconds (1..511).
- MAX_SNOOZE, 3: snoozes allowed per alarm event (0..7).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- hrs  in  5  live hours, 0..23.
- min  in  6  live minutes, 0..59.
- sec  in  6  live seconds, 0..59.
- din  in  6  programming data.
- addr  in  2  2 = alarm minutes, 3 = alarm hours; 0 and 1 ignored.
- load  in  1  write din to the addressed alarm register.
- arm  in  1  level; 1 = alarm enabled.
- snooze  in  1  single-cycle request.
- stop  in  1  single-cycle request.
- buzzer  out  1  alarm sound drive.
- al_state  out  2  0 IDLE, 1 ARMED, 2 RING, 3 SNOOZE.
- al_hrs  out  5  programmed alarm hours.
- al_min  out  6  programmed alarm minutes.
- snz_left  out  3  remaining snoozes.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates occur on the rising edge of clk.
- Reset values: al_state = IDLE, buzzer = 0, al_hrs = 0, al_min = 0, snz_left = 0, all counters 0, sec_q = 0.
- Second event (tick): registered sec_q follows sec every cycle. tick = (sec != sec_q). Loading the clock's seconds also produces a tick; this is accepted.
- Match: tick && sec == 0 && hrs == al_hrs && min == al_min.
- Programming:
  - load with addr = 3 writes al_hrs only if din <= 23; load with addr = 2 writes al_min only if din <= 59.
  - Out-of-range values leave the register unchanged.
  - Writes are accepted in every state and take effect the next cycle. They do not disturb an active RING or SNOOZE.
- FSM priority within a state, highest first: arm = 0, then stop, then snooze, then timers.
  - IDLE: arm = 1 -> ARMED.
  - ARMED:
    - arm = 0 -> IDLE.
    - match -> RING; ring_cnt = 0; snz_left = MAX_SNOOZE.
  - RING:
    - arm = 0 -> IDLE.
    - stop -> ARMED.
    - snooze && snz_left != 0 -> SNOOZE; snz_cnt = SNOOZE_SEC; snz_left decrements.
    - snooze while snz_left = 0 is ignored.
    - ring_cnt increments on each tick; the tick that makes ring_cnt reach RING_SEC -> ARMED.
  - SNOOZE:
    - arm = 0 -> IDLE.
    - stop -> ARMED.
    - snz_cnt decrements on each tick; the tick on which it reaches 0 -> RING with ring_cnt = 0. snz_left is not reloaded.
- buzzer is registered: 1 exactly in the cycles where al_state = RING, so no extra latency relative to al_state.
- Leaving RING or SNOOZE for ARMED does not re-trigger in the same minute, because match needs sec == 0 on a new tick.
- Re-arming within the match second (arm toggled while sec = 0) does not trigger.
- A match arriving while in RING or SNOOZE is ignored.
- Counters are sized to $clog2(512) = 9 bits.
- snz_left is 0 outside RING and SNOOZE after stop, timeout or disarm.

Optional Feature:
- Macro: HMS_ALARM_BEEP_EN.
- Defined: in RING, buzzer toggles on every tick, starting at 1 on RING entry, giving a 1 s on / 1 s off beep.
- Undefined: buzzer is steady 1 throughout RING.
- In both cases buzzer = 0 outside RING.

Decomposition:
- Package hms_alarm_pkg:
  - State encoding constants ST_IDLE/ST_ARMED/ST_RING/ST_SNOOZE.
  - Address codes ADDR_MIN = 2, ADDR_HRS = 3.
  - Limits HRS_MAX = 23, MIN_MAX = 59.
  - Counter width constant CNT_W = 9.
- Sub-module hms_sec_tick: registers sec and emits the one-cycle tick. It is reusable by other consumers of the time counter.

Test Plan:
- Reset, then load addr = 3 din = 7 and addr = 2 din = 30, arm = 1; drive 07:29:59 -> 07:30:00 -> al_state = RING and buzzer = 1 from the cycle after the 07:30:00 tick; snz_left = 3.
- Ring with no input for 60 ticks -> returns to ARMED with buzzer = 0 after the 60th tick; 07:31:00 does not re-ring.
- RING, pulse snooze -> SNOOZE, snz_left = 2; 300 ticks -> RING. Repeat until snz_left = 0; a further snooze is ignored and buzzer stays 1.
- Load addr = 3 din = 24 and addr = 2 din = 60 -> al_hrs and al_min are unchanged. Load during RING -> registers update and RING continues.
- In RING, assert stop and snooze in the same cycle -> ARMED. In SNOOZE, drop arm -> IDLE and snz_left = 0.
- Assert rst mid-SNOOZE -> next cycle: IDLE, buzzer = 0, al_hrs = 0, al_min = 0. With HMS_ALARM_BEEP_EN defined, buzzer in RING reads 1,0,1,0 on successive ticks.
